// File: rtl/spi_pkg.sv
`default_nettype none
// =============================================================================
// spi_pkg : types and constants shared by the SPI master and slave blocks.
// Rev 1.0
// =============================================================================
package spi_pkg;

   localparam int         SPI_SYNC_STAGES_MIN   = 2;
   localparam logic [7:0] SPI_IDLE_BYTE_DEFAULT = 8'h00;

   localparam int         SPI_MASTER_CLK_DIV    = 8;
   localparam logic       SPI_MASTER_CPOL       = 1'b0;
   localparam logic       SPI_MASTER_CPHA       = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } spi_slave_state_t;

   function automatic logic [7:0] spi_next_tx(input logic       full,
                                              input logic [7:0] held,
                                              input logic [7:0] idle_byte);
      return full ? held : idle_byte;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// =============================================================================
// spi_sync_edge : multi-flop synchronizer with rise/fall detection on the output.
// Rev 1.0
// =============================================================================
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_chain;
   logic              r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_chain <= {STAGES{RESET_VAL}};
         r_prev  <= RESET_VAL;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
         r_prev  <= r_chain[STAGES-1];
      end
   end

   assign o_sync = r_chain[STAGES-1];
   assign o_rise =  r_chain[STAGES-1] & ~r_prev;
   assign o_fall = ~r_chain[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// =============================================================================
// spi_slave : mode-0 SPI slave with one-byte transmit buffer, oversampled by clk.
// Rev 1.0
// =============================================================================
module spi_slave
   import spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss_n,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy
);

   if (SYNC_STAGES < SPI_SYNC_STAGES_MIN) begin : g_bad_stages
      $error("spi_slave: SYNC_STAGES must be at least 2");
   end

   logic w_ss_sync, w_ss_rise, w_ss_fall;
   logic w_sck_level_unused, w_sck_rise, w_sck_fall;
   logic w_mosi;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk     (clk),
      .rst     (rst),
      .i_async (ss_n),
      .o_sync  (w_ss_sync),
      .o_rise  (w_ss_rise),
      .o_fall  (w_ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .clk     (clk),
      .rst     (rst),
      .i_async (sck),
      .o_sync  (w_sck_level_unused),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   // mosi goes through the same depth as sck so a detected rise sees matching data
   logic [SYNC_STAGES-1:0] r_mosi_chain;

   always_ff @(posedge clk) begin
      if (rst) r_mosi_chain <= '0;
      else     r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], mosi};
   end

   assign w_mosi = r_mosi_chain[SYNC_STAGES-1];

   spi_slave_state_t r_state;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_tx_sr;
   logic [7:0]       r_rx_sr;
   logic [7:0]       r_txbuf;
   logic             r_txbuf_full;
   logic             r_byte_done;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;

   logic [7:0] w_next_tx;
   logic [7:0] w_rx_next;

   assign w_next_tx = spi_next_tx(r_txbuf_full, r_txbuf, IDLE_BYTE);
   assign w_rx_next = {r_rx_sr[6:0], w_mosi};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= 3'd0;
         r_tx_sr      <= 8'h00;
         r_rx_sr      <= 8'h00;
         r_txbuf      <= 8'h00;
         r_txbuf_full <= 1'b0;
         r_byte_done  <= 1'b0;
         r_rx_data    <= 8'h00;
         r_rx_valid   <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (w_ss_rise) begin
            // deselect drops any partial byte; the consumed tx byte is not kept
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
            r_tx_sr     <= 8'h00;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_ss_fall) r_state <= ST_LOAD;
               end
               ST_LOAD: begin
                  r_tx_sr      <= w_next_tx;
                  r_txbuf_full <= 1'b0;
                  r_bit_cnt    <= 3'd0;
                  r_byte_done  <= 1'b0;
                  r_state      <= ST_SHIFT;
               end
               ST_SHIFT: begin
                  if (w_sck_rise) begin
                     r_rx_sr   <= w_rx_next;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_rx_data   <= w_rx_next;
                        r_rx_valid  <= 1'b1;
                        r_byte_done <= 1'b1;
                     end
                  end
                  if (w_sck_fall) begin
                     if (r_byte_done) begin
                        r_tx_sr      <= w_next_tx;
                        r_txbuf_full <= 1'b0;
                        r_byte_done  <= 1'b0;
                     end else begin
                        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
         // placed last so a write into an already-empty buffer survives a consume
         if (tx_load && !r_txbuf_full) begin
            r_txbuf      <= tx_data;
            r_txbuf_full <= 1'b1;
         end
      end
   end

   assign busy     = ~w_ss_sync;
   assign miso_oe  = ~w_ss_sync;
   assign miso     = ~w_ss_sync & r_tx_sr[7];
   assign tx_ready = ~r_txbuf_full;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// =============================================================================
// tb_spi_slave : bus-master stimulus with a frame-level model of the slave.
// Rev 1.0
// =============================================================================
module tb_spi_slave;

   localparam int         HALF   = 5;
   localparam logic [7:0] IDLE_B = 8'h00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss_n = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, busy;
   logic [7:0] rx_data;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] m_tx   [4];
   logic [7:0] m_rx   [4];
   logic [7:0] ld_val [4];
   bit         ld_en  [4];
   logic [7:0] rxq    [$];

   spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
      .clk      (clk),
      .rst      (rst),
      .ss_n     (ss_n),
      .sck      (sck),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) rxq.push_back(rx_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] v);
      tx_data = v;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic clear_ld();
      for (int i = 0; i < 4; i++) begin
         ld_en[i]  = 1'b0;
         ld_val[i] = 8'h00;
         m_rx[i]   = 8'h00;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     miso,     1'b0);
      check({tag, "_oe"},       miso_oe,  1'b0);
      check({tag, "_busy"},     busy,     1'b0);
      check({tag, "_ready"},    tx_ready, 1'b1);
      check({tag, "_rxdata"},   rx_data,  8'h00);
      check({tag, "_rxvalid"},  rx_valid, 1'b0);
   endtask

   // abort_bits != 0 stops the last byte after that many bits; use_rst aborts with rst
   task automatic frame(input int nbytes, input int abort_bits, input bit use_rst);
      int nb;
      @(negedge clk);
      ss_n = 1'b0;
      wait_clk(6);
      check("oe_sel", miso_oe, 1'b1);
      check("busy_sel", busy, 1'b1);
      for (int b = 0; b < nbytes; b++) begin
         nb = (b == nbytes - 1 && abort_bits != 0) ? abort_bits : 8;
         for (int i = 0; i < nb; i++) begin
            mosi = m_tx[b][7-i];
            wait_clk(HALF);
            m_rx[b][7-i] = miso;
            sck = 1'b1;
            if (i == 2 && ld_en[b]) begin
               load(ld_val[b]);
               check("rdy_full", tx_ready, 1'b0);
               load(~ld_val[b]);
            end
            wait_clk(HALF);
            sck = 1'b0;
         end
      end
      if (use_rst) begin
         rst = 1'b1;
         wait_clk(2);
         check_reset_outputs("rst_mid");
         ss_n = 1'b1;
         wait_clk(3);
         rst = 1'b0;
         wait_clk(4);
      end else begin
         wait_clk(HALF);
         ss_n = 1'b1;
         wait_clk(8);
         check("oe_idle", miso_oe, 1'b0);
      end
   endtask

   task automatic run_frame(input int nbytes, input int abort_bits, input bit use_rst,
                            input bit pre_en, input logic [7:0] pre_val);
      int         base;
      int         ncomplete;
      logic [7:0] exp;
      if (pre_en) load(pre_val);
      base = rxq.size();
      frame(nbytes, abort_bits, use_rst);
      ncomplete = (abort_bits != 0) ? nbytes - 1 : nbytes;
      check("rx_cnt", rxq.size() - base, ncomplete);
      for (int b = 0; b < ncomplete; b++) begin
         if (b == 0) exp = pre_en ? pre_val : IDLE_B;
         else        exp = ld_en[b-1] ? ld_val[b-1] : IDLE_B;
         check("miso_byte", m_rx[b], exp);
         if (rxq.size() > base + b) check("rx_byte", rxq[base+b], m_tx[b]);
      end
      check("rdy_end", tx_ready, 1'b1);
   endtask

   initial begin
      int nbytes, abort_bits, base;
      bit pre_en;
      logic [7:0] pre_val;

      clear_ld();
      wait_clk(3);
      check_reset_outputs("rst_init");
      rst = 1'b0;
      wait_clk(4);
      check_reset_outputs("post_rst");

      // single byte with preloaded buffer
      m_tx[0] = 8'h3C;
      run_frame(1, 0, 0, 1'b1, 8'hA5);
      check("rx_last_3c", rx_data, 8'h3C);

      // three-byte frame, buffer refilled each byte
      clear_ld();
      m_tx[0] = 8'hDE; m_tx[1] = 8'hAD; m_tx[2] = 8'hBE;
      ld_en[0] = 1'b1; ld_val[0] = 8'h02;
      ld_en[1] = 1'b1; ld_val[1] = 8'h03;
      run_frame(3, 0, 0, 1'b1, 8'h01);

      // empty buffer sends idle byte
      clear_ld();
      m_tx[0] = 8'hFF;
      run_frame(1, 0, 0, 1'b0, 8'h00);
      check("rx_last_ff", rx_data, 8'hFF);

      // partial byte discarded, then a clean frame
      m_tx[0] = 8'h6E;
      run_frame(1, 5, 0, 1'b0, 8'h00);
      check("rx_hold", rx_data, 8'hFF);
      m_tx[0] = 8'h81;
      run_frame(1, 0, 0, 1'b0, 8'h00);
      check("rx_last_81", rx_data, 8'h81);

      // reset mid-frame, then a clean frame
      m_tx[0] = 8'h55;
      run_frame(1, 3, 1, 1'b1, 8'h77);
      m_tx[0] = 8'hC3;
      run_frame(1, 0, 0, 1'b1, 8'h9A);
      check("rx_last_c3", rx_data, 8'hC3);

      // sck activity while deselected
      load(8'h5A);
      base = rxq.size();
      for (int i = 0; i < 16; i++) begin
         mosi = 1'($urandom_range(0, 1));
         sck  = ~sck;
         wait_clk(HALF);
         if (i == 7) check("oe_desel", miso_oe, 1'b0);
      end
      check("rx_desel", rxq.size() - base, 0);
      check("rdy_desel", tx_ready, 1'b0);
      m_tx[0] = 8'h24;
      run_frame(1, 0, 0, 1'b1, 8'h5A);

      // randomized frames
      for (int t = 0; t < 20; t++) begin
         clear_ld();
         nbytes     = $urandom_range(1, 4);
         abort_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         pre_en     = 1'($urandom_range(0, 1));
         pre_val    = 8'($urandom);
         for (int b = 0; b < nbytes; b++) begin
            m_tx[b]   = 8'($urandom);
            ld_val[b] = 8'($urandom);
            ld_en[b]  = ($urandom_range(0, 2) != 0) &&
                        !(b == nbytes - 1 && abort_bits != 0);
         end
         run_frame(nbytes, abort_bits, 0, pre_en, pre_val);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sck, ss_n and mosi (minimum 2).
REQ-002 Parameter IDLE_BYTE, default 8'h00, byte shifted out when the transmit buffer is empty.
REQ-003 clk  in  1  system clock; one clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ss_n  in  1  asynchronous chip select from the bus master, active low.
REQ-006 sck  in  1  asynchronous SPI clock, mode 0 (idle low).
REQ-007 mosi  in  1  asynchronous serial data from the master.
REQ-008 miso  out  1  serial data to the master.
REQ-009 miso_oe  out  1  output enable for the external miso tristate; high while selected.
REQ-010 tx_data  in  8  byte to transmit next.
REQ-011 tx_load  in  1  writes tx_data into the transmit buffer when tx_ready is high.
REQ-012 tx_ready  out  1  transmit buffer empty.
REQ-013 rx_data  out  8  last complete received byte.
REQ-014 rx_valid  out  1  one-cycle pulse when rx_data is updated.
REQ-015 busy  out  1  high while selected (synchronized ss_n low).

Function
REQ-016 The block SHALL pass sck, ss_n and mosi through SYNC_STAGES flops and use only the synchronized copies internally.
REQ-017 The block SHALL require clk frequency of at least 4x sck frequency; faster sck is out of scope.
REQ-018 FSM states: IDLE (ss_n high), LOAD (one cycle after selection), SHIFT (byte in progress).
REQ-019 IDLE->LOAD on the synchronized ss_n falling edge; LOAD->SHIFT unconditionally; SHIFT->IDLE on the synchronized ss_n rising edge from any state.
REQ-020 In LOAD the block SHALL copy the transmit buffer into the 8-bit tx shift register (IDLE_BYTE if empty), mark the buffer empty, and clear the 3-bit bit counter.
REQ-021 miso SHALL equal tx shift register bit 7 while busy and 0 otherwise; MSB first.
REQ-022 On each synchronized sck rising edge in SHIFT the block SHALL shift mosi into the rx shift register LSB and increment the bit counter (wraps 7->0).
REQ-023 On each synchronized sck falling edge in SHIFT the block SHALL shift the tx shift register left by one, except after the 8th rising edge.
REQ-024 On the 8th rising edge, the block SHALL register the completed byte into rx_data and pulse rx_valid in the next clk cycle.
REQ-025 On the falling edge after the 8th rising edge, the block SHALL reload the tx shift register from the buffer (IDLE_BYTE if empty) and mark the buffer empty; frames of any byte count SHALL work back-to-back.
REQ-026 tx_ready SHALL be high exactly when the buffer is empty; tx_load with tx_ready low SHALL be ignored.
REQ-027 tx_load in the same cycle as a buffer consumption SHALL be ignored, because tx_ready is low that cycle.
REQ-028 ss_n rising mid-byte SHALL discard the partial byte: no rx_valid, bit counter cleared, and the loaded tx byte is not re-sent.
REQ-029 rx_data SHALL hold its value until the next complete byte; rx_valid has no back-pressure.
REQ-030 sck edges while ss_n is high SHALL be ignored.

Reset
REQ-031 rst SHALL force state IDLE, bit counter 0, both shift registers 0, buffer empty, synchronizers to ss_n=1/sck=0/mosi=0.
REQ-032 Output values during rst: miso=0, miso_oe=0, busy=0, tx_ready=1, rx_data=8'h00, rx_valid=0.
REQ-033 rst asserted mid-frame SHALL abort without rx_valid; the block SHALL resume at the next ss_n falling edge after rst releases.

Structure
REQ-034 State encodings and IDLE_BYTE default SHALL live in a shared spi package alongside the master's constants.
REQ-035 One sub-module, spi_sync_edge (synchronizer plus rise/fall detect), SHALL be instantiated for sck and ss_n.

Verification
REQ-036 Buffer loaded with 8'hA5, master sends 8'h3C in a single-byte frame -> master reads 8'hA5, rx_data=8'h3C, exactly one rx_valid pulse, tx_ready returns high.
REQ-037 Three-byte frame, buffer refilled each time tx_ready rises with 8'h01,8'h02,8'h03; master sends 8'hDE,8'hAD,8'hBE -> master reads 01,02,03; three rx_valid pulses carrying DE,AD,BE.
REQ-038 Empty buffer, master sends 8'hFF -> master reads IDLE_BYTE 8'h00, rx_data=8'hFF.
REQ-039 ss_n raised after 5 bits, then a new frame with 8'h81 -> no rx_valid for the partial byte, next rx_data=8'h81.
REQ-040 rst pulsed after bit 3 -> all outputs at reset values; the next full frame transfers correctly.
REQ-041 sck toggled 16 times with ss_n high -> no rx_valid, miso_oe=0, buffer contents unchanged.
